// File: rtl/mem_bus_if.sv
// Request/acknowledge data-memory bus between the load/store sequencer and memory.
// The sequencer is the master; the memory model or controller is the slave.
interface mem_bus_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;

   modport master (
      output req,
      output we,
      output addr,
      output be,
      output wdata,
      input  ack,
      input  rdata
   );

   modport slave (
      input  req,
      input  we,
      input  addr,
      input  be,
      input  wdata,
      output ack,
      output rdata
   );
endinterface

// File: rtl/mem_access_sequencer.sv
// Multi-cycle load/store sequencer that stalls a single-cycle core while a bus access is in flight.
// Optional MEM_MISALIGN_TRAP_EN: trap misaligned half/word accesses without touching the bus.
module mem_access_sequencer #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        nRst,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [1:0]  size,
   input  logic        loadUnsigned,
   input  logic [31:0] addr,
   input  logic [31:0] storeData,
   output logic        stall,
   output logic        done,
   output logic [31:0] loadData,
   output logic        err,
   mem_bus_if.master   bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [1:0]    state;
   logic [1:0]    lane;
   logic [1:0]    sz_q;
   logic          uns_q;
   logic [CW-1:0] cnt;

   logic          go;
   logic          sz_b;
   logic          sz_h;
   logic          mis;
   logic          expire;
   logic [3:0]    be_nxt;
   logic [31:0]   wd_nxt;

   logic          q_b;
   logic          q_h;
   logic [7:0]    byte_v;
   logic [15:0]   half_v;
   logic [31:0]   ld_ext;

   assign go   = memRead | memWrite;
   assign sz_b = (size == 2'b00);
   assign sz_h = (size == 2'b01);

   assign stall = ((state == S_IDLE) & go) | (state == S_REQ);

`ifdef MEM_MISALIGN_TRAP_EN
   assign mis = (sz_h & addr[0]) | (~sz_b & ~sz_h & (|addr[1:0]));
`else
   assign mis = 1'b0;
`endif

   // Expiry is judged on the cycle that would make the count reach TIMEOUT,
   // so bus_req stays high for exactly TIMEOUT cycles.
   assign expire = (TIMEOUT != 0) && (32'(cnt) == TIMEOUT - 32'd1);

   always_comb begin
      be_nxt = 4'b1111;
      wd_nxt = storeData;
      unique case (1'b1)
         sz_b: begin
            be_nxt = 4'b0001 << addr[1:0];
            wd_nxt = {4{storeData[7:0]}};
         end
         sz_h: begin
            be_nxt = 4'b0011 << {addr[1], 1'b0};
            wd_nxt = {2{storeData[15:0]}};
         end
         default: ;
      endcase
   end

   assign q_b    = (sz_q == 2'b00);
   assign q_h    = (sz_q == 2'b01);
   assign byte_v = bus.rdata[{lane, 3'b000} +: 8];
   assign half_v = lane[1] ? bus.rdata[31:16] : bus.rdata[15:0];

   always_comb begin
      ld_ext = bus.rdata;
      unique case (1'b1)
         q_b:     ld_ext = {{24{~uns_q & byte_v[7]}}, byte_v};
         q_h:     ld_ext = {{16{~uns_q & half_v[15]}}, half_v};
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state     <= S_IDLE;
         lane      <= 2'b00;
         sz_q      <= 2'b00;
         uns_q     <= 1'b0;
         cnt       <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         loadData  <= 32'h0;
         bus.req   <= 1'b0;
         bus.we    <= 1'b0;
         bus.addr  <= 32'h0;
         bus.be    <= 4'h0;
         bus.wdata <= 32'h0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (go) begin
                  lane  <= addr[1:0];
                  sz_q  <= size;
                  uns_q <= loadUnsigned;
                  cnt   <= '0;
                  if (mis) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     state     <= S_REQ;
                     bus.req   <= 1'b1;
                     bus.we    <= memWrite;
                     bus.addr  <= {addr[31:2], 2'b00};
                     bus.be    <= be_nxt;
                     bus.wdata <= wd_nxt;
                  end
               end
            end
            S_REQ: begin
               if (bus.ack) begin
                  state   <= S_DONE;
                  bus.req <= 1'b0;
                  bus.we  <= 1'b0;
                  done    <= 1'b1;
                  if (!bus.we) loadData <= ld_ext;
               end else if (expire) begin
                  state    <= S_DONE;
                  bus.req  <= 1'b0;
                  bus.we   <= 1'b0;
                  done     <= 1'b1;
                  err      <= 1'b1;
                  loadData <= 32'h0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with TIMEOUT=4.
// Memory side is driven by hand: ack on a chosen REQ cycle or never.
module tb_mem_access_sequencer;

   logic        clk = 1'b0;
   logic        nRst = 1'b0;
   logic        memRead = 1'b0;
   logic        memWrite = 1'b0;
   logic [1:0]  size = 2'b00;
   logic        loadUnsigned = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] storeData = 32'h0;
   logic        stall;
   logic        done;
   logic [31:0] loadData;
   logic        err;

   mem_bus_if bus ();

   mem_access_sequencer #(.TIMEOUT(4)) dut (
      .clk          (clk),
      .nRst         (nRst),
      .memRead      (memRead),
      .memWrite     (memWrite),
      .size         (size),
      .loadUnsigned (loadUnsigned),
      .addr         (addr),
      .storeData    (storeData),
      .stall        (stall),
      .done         (done),
      .loadData     (loadData),
      .err          (err),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic [3:0]  s_be;
   logic [31:0] s_addr;
   logic        s_we;
   logic [31:0] s_wdata;
   logic        d_stall;
   int          n_stall;
   int          n_req;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issue one access and run it to its done cycle; ack on the ack_at-th REQ cycle (0 = never).
   task automatic run_acc(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] sd,
                          input int ack_at, input logic [31:0] rdat);
      bit seen;
      seen    = 0;
      n_stall = 0;
      n_req   = 0;
      s_be    = 4'h0;
      s_addr  = 32'h0;
      s_we    = 1'b0;
      s_wdata = 32'h0;
      @(negedge clk);
      memRead = rd; memWrite = wr; size = sz; loadUnsigned = uns;
      addr = a; storeData = sd; bus.ack = 1'b0;
      #1;
      if (stall) n_stall++;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         bus.ack = 1'b0;
         #1;
         if (done) begin
            seen = 1;
            break;
         end
         if (bus.req) begin
            n_req++;
            s_be = bus.be; s_addr = bus.addr; s_we = bus.we; s_wdata = bus.wdata;
            if (n_req == ack_at) begin
               bus.ack = 1'b1;
               bus.rdata = rdat;
            end
         end
         #1;
         if (stall) n_stall++;
      end
      if (!seen) chk("done_budget", 32'd0, 32'd1);
      d_stall = stall;
      memRead = 1'b0;
      memWrite = 1'b0;
   endtask

   initial begin
      bus.ack = 1'b0;
      bus.rdata = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req", {31'd0, bus.req}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_ld", loadData, 32'h0);
      chk("rst_addr", bus.addr, 32'h0);
      chk("rst_be", {28'd0, bus.be}, 32'h0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      nRst = 1'b1;

      run_acc(1, 0, 2'b10, 0, 32'h104, 32'h0, 3, 32'hDEADBEEF);
      chk("lw_be", {28'd0, s_be}, 32'hF);
      chk("lw_addr", s_addr, 32'h104);
      chk("lw_we", {31'd0, s_we}, 32'd0);
      chk("lw_stall_n", n_stall, 4);
      chk("lw_req_n", n_req, 3);
      chk("lw_done_stall", {31'd0, d_stall}, 32'd0);
      chk("lw_ld", loadData, 32'hDEADBEEF);
      chk("lw_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      #1;
      chk("done_pulse", {31'd0, done}, 32'd0);
      chk("idle_req", {31'd0, bus.req}, 32'd0);

      run_acc(1, 0, 2'b00, 0, 32'h203, 32'h0, 1, 32'h80000000);
      chk("lb_be", {28'd0, s_be}, 32'h8);
      chk("lb_ld", loadData, 32'hFFFFFF80);
      chk("lb_stall_n", n_stall, 2);

      run_acc(1, 0, 2'b00, 1, 32'h203, 32'h0, 1, 32'h80000000);
      chk("lbu_ld", loadData, 32'h00000080);

      run_acc(0, 1, 2'b01, 0, 32'h12, 32'h0000ABCD, 2, 32'hFFFFFFFF);
      chk("sh_we", {31'd0, s_we}, 32'd1);
      chk("sh_be", {28'd0, s_be}, 32'hC);
      chk("sh_wd", s_wdata, 32'hABCDABCD);
      chk("sh_addr", s_addr, 32'h10);
      chk("sh_req_n", n_req, 2);
      chk("sh_ld_keep", loadData, 32'h00000080);

      run_acc(1, 0, 2'b01, 0, 32'h22, 32'h0, 1, 32'h80011234);
      chk("lh_be", {28'd0, s_be}, 32'hC);
      chk("lh_ld", loadData, 32'hFFFF8001);

      run_acc(1, 0, 2'b01, 1, 32'h20, 32'h0, 1, 32'h8001F234);
      chk("lhu_be", {28'd0, s_be}, 32'h3);
      chk("lhu_ld", loadData, 32'h0000F234);

      run_acc(0, 1, 2'b00, 0, 32'h7, 32'h123456A5, 1, 32'h0);
      chk("sb_be", {28'd0, s_be}, 32'h8);
      chk("sb_wd", s_wdata, 32'hA5A5A5A5);
      chk("sb_ld_keep", loadData, 32'h0000F234);

      run_acc(1, 0, 2'b10, 0, 32'h40, 32'h0, 4, 32'h11223344);
      chk("edge_req_n", n_req, 4);
      chk("edge_err", {31'd0, err}, 32'd0);
      chk("edge_ld", loadData, 32'h11223344);

      run_acc(1, 0, 2'b10, 0, 32'h80, 32'h0, 0, 32'h0);
      chk("to_req_n", n_req, 4);
      chk("to_done", {31'd0, done}, 32'd1);
      chk("to_err", {31'd0, err}, 32'd1);
      chk("to_ld", loadData, 32'h0);
      @(negedge clk);
      #1;
      chk("to_req_low", {31'd0, bus.req}, 32'd0);

      run_acc(1, 1, 2'b10, 0, 32'h50, 32'hCAFEF00D, 1, 32'h99999999);
      chk("rw_we", {31'd0, s_we}, 32'd1);
      chk("rw_wd", s_wdata, 32'hCAFEF00D);
      chk("rw_ld_keep", loadData, 32'h0);

      run_acc(1, 0, 2'b10, 0, 32'h102, 32'h0, 1, 32'h55667788);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("mis_req_n", n_req, 0);
      chk("mis_err", {31'd0, err}, 32'd1);
      chk("mis_stall_n", n_stall, 1);
      chk("mis_ld_keep", loadData, 32'h0);
`else
      chk("mis_addr", s_addr, 32'h100);
      chk("mis_be", {28'd0, s_be}, 32'hF);
      chk("mis_ld", loadData, 32'h55667788);
      chk("mis_err", {31'd0, err}, 32'd0);
`endif

      @(negedge clk);
      bus.ack = 1'b1;
      #1;
      @(negedge clk);
      bus.ack = 1'b0;
      #1;
      chk("stray_done", {31'd0, done}, 32'd0);
      chk("stray_req", {31'd0, bus.req}, 32'd0);

      memRead = 1'b1; size = 2'b10; addr = 32'h300;
      @(negedge clk);
      #1;
      chk("rr_req", {31'd0, bus.req}, 32'd1);
      nRst = 1'b0;
      #1;
      chk("rr_req_drop", {31'd0, bus.req}, 32'd0);
      memRead = 1'b0;
      @(negedge clk);
      #1;
      chk("rr_no_done", {31'd0, done}, 32'd0);
      chk("rr_ld", loadData, 32'h0);
      nRst = 1'b1;
      @(negedge clk);
      #1;
      chk("rr_no_done2", {31'd0, done}, 32'd0);

      run_acc(0, 1, 2'b10, 0, 32'h304, 32'h0BADCAFE, 1, 32'h0);
      chk("rr_sw_we", {31'd0, s_we}, 32'd1);
      chk("rr_sw_be", {28'd0, s_be}, 32'hF);
      chk("rr_sw_addr", s_addr, 32'h304);
      chk("rr_sw_err", {31'd0, err}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
